bcd_scan_counter: RTL

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_scan_counter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with wrap pulse and a multiplexed digit scanner
// that feeds a downstream BCD-to-7-segment decoder. Leading-zero blanking is optional.
module bcd_scan_counter #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        carry,
  output logic [3:0]  bcd,
  output logic [3:0]  dig_sel
);

  localparam int              PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;

  logic [15:0] load_clean;
  logic [15:0] inc_val;
  logic [15:0] dec_val;
  logic [15:0] count_next;
  logic        carry_next;
  logic        at_max;
  logic        at_min;

  // Digits above 9 are not representable; they load as 0.
  always_comb begin
    load_clean = '0;
    for (int i = 0; i < 4; i++) begin
      load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  // Decimal ripple increment and decrement, both resolved within one cycle.
  always_comb begin
    logic ci;
    logic bi;
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    inc_val = count;
    dec_val = count;
    ci      = 1'b1;
    bi      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ci) begin
        if (count[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
          ci = 1'b0;
        end
      end
      if (bi) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          bi = 1'b0;
        end
      end
    end
  end

  assign at_max = (count == 16'h9999);
  assign at_min = (count == 16'h0000);

  // Load outranks step; carry flags only a step that wraps the count.
  always_comb begin
    count_next = count;
    carry_next = 1'b0;
    if (load) begin
      count_next = load_clean;
    end else if (step) begin
      count_next = up ? inc_val : dec_val;
      carry_next = up ? at_max : at_min;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      count <= 16'h0000;
      carry <= 1'b0;
      presc <= '0;
      idx   <= 2'd0;
    end else begin
      count <= count_next;
      carry <= carry_next;
      if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Scan outputs: digit select from the index register, digit code from count.
  logic [3:0] sel_digit;
  logic       upper_zero;

  always_comb begin
    sel_digit  = count[3:0];
    upper_zero = 1'b0;
    case (idx)
      2'd0: begin
        sel_digit  = count[3:0];
        upper_zero = 1'b0;
      end
      2'd1: begin
        sel_digit  = count[7:4];
        upper_zero = (count[15:4] == 12'h000);
      end
      2'd2: begin
        sel_digit  = count[11:8];
        upper_zero = (count[15:8] == 8'h00);
      end
      default: begin
        sel_digit  = count[15:12];
        upper_zero = (count[15:12] == 4'h0);
      end
    endcase
  end

  assign bcd     = (BLANK_LZ && upper_zero) ? 4'hF : sel_digit;
  assign dig_sel = ~(4'b0001 << idx);

endmodule
